program_counter: RTL and testbench

- 16-bit 6502 program counter (PCL/PCH) with increment and bus-load logic.
- Sits directly upstream of the Address Bus Low and Address Bus High latches: it produces the address bytes and the load strobes that capture them.
- Contains a reset-vector sequencer that fetches the reset vector from memory before normal operation begins.

---
 rtl/program_counter.sv | 235 +++++++++++++++++++++++
 tb/tb_program_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// 6502 program counter with reset-vector fetch sequencer and address-latch drive.
// Optional split-carry datapath selected by defining PCH_CARRY_PIPE_EN.
module program_counter #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter int unsigned MEM_LATENCY  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pc_inc,
    input  logic       pcl_load_adl,
    input  logic       pch_load_adh,
    input  logic [7:0] adl_in,
    input  logic [7:0] adh_in,
    input  logic [7:0] data_in,
    input  logic       addr_req,
    output logic [7:0] pcl_out,
    output logic [7:0] pch_out,
    output logic [7:0] abl_out,
    output logic [7:0] abh_out,
    output logic       abl_load,
    output logic       abh_load,
    output logic       vector_busy,
    output logic       carry_pending
);

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;
    localparam logic [2:0]  LAT_LAST    = 3'(MEM_LATENCY);

    state_e     state_q, state_d;
    logic [2:0] lat_q, lat_d;
    logic       sent_q, sent_d;
    logic [7:0] pcl_q, pcl_d;
    logic [7:0] pch_q, pch_d;
    logic [7:0] abl_q, abl_d;
    logic [7:0] abh_q, abh_d;
    logic       abl_load_q, abl_load_d;
    logic       abh_load_q, abh_load_d;
    logic       busy_q, busy_d;

    logic [7:0] run_pcl_s;
    logic [7:0] run_pch_s;
    logic       any_load_s;

    assign any_load_s = pcl_load_adl | pch_load_adh;

`ifdef PCH_CARRY_PIPE_EN
    logic carry_q, carry_d;
    logic run_carry_s;

    // RUN-state PC update with the PCH carry deferred by one cycle.
    always_comb begin
        run_pcl_s   = pcl_q;
        run_pch_s   = pch_q;
        run_carry_s = 1'b0;
        if (carry_q) begin
            // The deferred carry is only cancelled by a PCH load.
            if (pch_load_adh) begin
                run_pch_s = adh_in;
            end else begin
                run_pch_s = pch_q + 8'd1;
            end
            if (pcl_load_adl) begin
                run_pcl_s = adl_in;
            end else if (pch_load_adh) begin
                run_pcl_s = pcl_q;
            end else if (pc_inc) begin
                run_pcl_s = pcl_q + 8'd1;
            end else begin
                run_pcl_s = pcl_q;
            end
        end else if (any_load_s) begin
            run_pcl_s = pcl_load_adl ? adl_in : pcl_q;
            run_pch_s = pch_load_adh ? adh_in : pch_q;
        end else if (pc_inc) begin
            run_pcl_s   = pcl_q + 8'd1;
            run_carry_s = (pcl_q == 8'hFF);
        end else begin
            run_pcl_s = pcl_q;
        end
    end

    assign carry_pending = carry_q;
`else
    logic [15:0] pc_inc_s;

    assign pc_inc_s = {pch_q, pcl_q} + 16'd1;

    // RUN-state PC update: loads beat increment, carry applied in the same cycle.
    always_comb begin
        run_pcl_s = pcl_q;
        run_pch_s = pch_q;
        if (any_load_s) begin
            run_pcl_s = pcl_load_adl ? adl_in : pcl_q;
            run_pch_s = pch_load_adh ? adh_in : pch_q;
        end else if (pc_inc) begin
            run_pcl_s = pc_inc_s[7:0];
            run_pch_s = pc_inc_s[15:8];
        end else begin
            run_pcl_s = pcl_q;
        end
    end

    assign carry_pending = 1'b0;
`endif

    // Sequencer: vector fetch, RUN-state PC commit and address-latch drive.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        sent_d     = sent_q;
        pcl_d      = pcl_q;
        pch_d      = pch_q;
        abl_d      = abl_q;
        abh_d      = abh_q;
        abl_load_d = 1'b0;
        abh_load_d = 1'b0;
        busy_d     = busy_q;
`ifdef PCH_CARRY_PIPE_EN
        carry_d    = carry_q;
`endif
        case (state_q)
            VEC_LO: begin
                if (!sent_q) begin
                    abl_d      = RESET_VECTOR[7:0];
                    abh_d      = RESET_VECTOR[15:8];
                    abl_load_d = 1'b1;
                    abh_load_d = 1'b1;
                    sent_d     = 1'b1;
                    lat_d      = 3'd0;
                end else if (lat_q == LAT_LAST) begin
                    // Low byte arrives; the high-byte strobe goes out on the same edge.
                    pcl_d      = data_in;
                    abl_d      = VEC_HI_ADDR[7:0];
                    abh_d      = VEC_HI_ADDR[15:8];
                    abl_load_d = 1'b1;
                    abh_load_d = 1'b1;
                    lat_d      = 3'd0;
                    state_d    = VEC_HI;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            VEC_HI: begin
                if (lat_q == LAT_LAST) begin
                    pch_d   = data_in;
                    busy_d  = 1'b0;
                    lat_d   = 3'd0;
                    sent_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RUN: begin
                pcl_d = run_pcl_s;
                pch_d = run_pch_s;
`ifdef PCH_CARRY_PIPE_EN
                carry_d = run_carry_s;
`endif
                // Drive the pre-update PC so the latch sees the current fetch address.
                if (addr_req) begin
                    abl_d      = pcl_q;
                    abh_d      = pch_q;
                    abl_load_d = 1'b1;
                    abh_load_d = 1'b1;
                end else begin
                    abl_d = abl_q;
                    abh_d = abh_q;
                end
            end
            default: begin
                state_d = VEC_LO;
                lat_d   = 3'd0;
                sent_d  = 1'b0;
                busy_d  = 1'b1;
`ifdef PCH_CARRY_PIPE_EN
                carry_d = 1'b0;
`endif
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= VEC_LO;
            lat_q      <= 3'd0;
            sent_q     <= 1'b0;
            pcl_q      <= 8'h00;
            pch_q      <= 8'h00;
            abl_q      <= RESET_VECTOR[7:0];
            abh_q      <= RESET_VECTOR[15:8];
            abl_load_q <= 1'b0;
            abh_load_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            sent_q     <= sent_d;
            pcl_q      <= pcl_d;
            pch_q      <= pch_d;
            abl_q      <= abl_d;
            abh_q      <= abh_d;
            abl_load_q <= abl_load_d;
            abh_load_q <= abh_load_d;
            busy_q     <= busy_d;
        end
    end

`ifdef PCH_CARRY_PIPE_EN
    // Deferred-carry flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end
`endif

    assign pcl_out     = pcl_q;
    assign pch_out     = pch_q;
    assign abl_out     = abl_q;
    assign abh_out     = abh_q;
    assign abl_load    = abl_load_q;
    assign abh_load    = abh_load_q;
    assign vector_busy = busy_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (default MEM_LATENCY=1).
module tb_program_counter;

`ifdef PCH_CARRY_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       pc_inc;
    logic       pcl_load_adl;
    logic       pch_load_adh;
    logic [7:0] adl_in;
    logic [7:0] adh_in;
    logic [7:0] data_in;
    logic       addr_req;
    logic [7:0] pcl_out;
    logic [7:0] pch_out;
    logic [7:0] abl_out;
    logic [7:0] abh_out;
    logic       abl_load;
    logic       abh_load;
    logic       vector_busy;
    logic       carry_pending;

    logic [7:0] vec_lo_v;
    logic [7:0] vec_hi_v;
    int         checks_total;
    int         checks_passed;
    int         pulse_cnt;

    program_counter dut (
        .clk          (clk),
        .reset        (reset),
        .pc_inc       (pc_inc),
        .pcl_load_adl (pcl_load_adl),
        .pch_load_adh (pch_load_adh),
        .adl_in       (adl_in),
        .adh_in       (adh_in),
        .data_in      (data_in),
        .addr_req     (addr_req),
        .pcl_out      (pcl_out),
        .pch_out      (pch_out),
        .abl_out      (abl_out),
        .abh_out      (abh_out),
        .abl_load     (abl_load),
        .abh_load     (abh_load),
        .vector_busy  (vector_busy),
        .carry_pending(carry_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the vector bytes for whatever address the latches hold.
    assign data_in = ({abh_out, abl_out} == 16'hFFFC) ? vec_lo_v :
                     ({abh_out, abl_out} == 16'hFFFD) ? vec_hi_v : 8'h00;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic inc, input logic ll, input logic lh,
                         input logic [7:0] adl, input logic [7:0] adh, input logic req);
        pc_inc       = inc;
        pcl_load_adl = ll;
        pch_load_adh = lh;
        adl_in       = adl;
        adh_in       = adh;
        addr_req     = req;
    endtask

    task automatic check_strobe(input string tag, input logic exp_ld, input logic [15:0] exp_addr);
        check_eq({tag, "_ld"}, {14'd0, abh_load, abl_load}, exp_ld ? 16'h0003 : 16'h0000);
        check_eq({tag, "_ab"}, {abh_out, abl_out}, exp_addr);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"}, {pch_out, pcl_out}, 16'h0000);
        check_eq({tag, "_ab"}, {abh_out, abl_out}, 16'hFFFC);
        check_eq({tag, "_flags"}, {12'd0, abl_load, abh_load, vector_busy, carry_pending}, 16'h0002);
    endtask

    task automatic load_pc(input logic [15:0] v);
        drive(1'b0, 1'b1, 1'b1, v[7:0], v[15:8], 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    // Reset has just been released; inputs are driven active to show they are ignored.
    task automatic run_vector(input string tag, input logic [15:0] exp_pc);
        drive(1'b1, 1'b1, 1'b1, 8'h55, 8'hAA, 1'b1);
        step();
        check_strobe({tag, "_e1"}, 1'b1, 16'hFFFC);
        step();
        check_strobe({tag, "_e2"}, 1'b0, 16'hFFFC);
        check_eq({tag, "_busy2"}, {15'd0, vector_busy}, 16'h0001);
        step();
        check_strobe({tag, "_e3"}, 1'b1, 16'hFFFD);
        check_eq({tag, "_pcl3"}, {8'h00, pcl_out}, {8'h00, exp_pc[7:0]});
        step();
        check_strobe({tag, "_e4"}, 1'b0, 16'hFFFD);
        check_eq({tag, "_busy4"}, {15'd0, vector_busy}, 16'h0001);
        step();
        check_eq({tag, "_busy5"}, {15'd0, vector_busy}, 16'h0000);
        check_eq({tag, "_pc5"}, {pch_out, pcl_out}, exp_pc);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        vec_lo_v      = 8'h34;
        vec_hi_v      = 8'h12;
        reset         = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #2;
        check_reset_state("rst_async");
        step();
        check_reset_state("rst_held");
        reset = 1'b0;
        run_vector("vec", 16'h1234);

        load_pc(16'h12FF);
        check_eq("load_12ff", {pch_out, pcl_out}, 16'h12FF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check_eq("inc_carry", {pch_out, pcl_out}, PIPE ? 16'h1200 : 16'h1300);
        check_eq("inc_carry_flag", {15'd0, carry_pending}, {15'd0, PIPE});
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check_eq("carry_settle", {pch_out, pcl_out}, 16'h1300);
        check_eq("carry_settle_flag", {15'd0, carry_pending}, 16'h0000);

        load_pc(16'hFFFF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check_eq("wrap", {pch_out, pcl_out}, PIPE ? 16'hFF00 : 16'h0000);
        check_eq("wrap_flag", {15'd0, carry_pending}, {15'd0, PIPE});
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check_eq("wrap_settle", {pch_out, pcl_out}, 16'h0000);

        // Cases whose final PC is identical with or without the deferred carry.
        load_pc(16'h12FF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'hC0, 1'b0);
        step();
        check_eq("pend_pch_load", {pch_out, pcl_out}, 16'hC000);
        check_eq("pend_pch_flag", {15'd0, carry_pending}, 16'h0000);

        load_pc(16'h12FF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check_eq("pend_inc", {pch_out, pcl_out}, 16'h1301);

        load_pc(16'h12FF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b1);
        step();
        check_eq("pend_pcl_load", {pch_out, pcl_out}, 16'h1380);
        check_strobe("pend_addr", 1'b1, PIPE ? 16'h1200 : 16'h1300);

        load_pc(16'h4010);
        drive(1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
        step();
        check_eq("ld_beats_inc", {pch_out, pcl_out}, 16'h4080);
        load_pc(16'h4010);
        drive(1'b1, 1'b1, 1'b1, 8'h80, 8'hC0, 1'b0);
        step();
        check_eq("ld_both_inc", {pch_out, pcl_out}, 16'hC080);

        load_pc(16'h0200);
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
            step();
            pulse_cnt += int'(abl_load);
            check_strobe($sformatf("areq%0d", i), 1'b1, 16'h0200 + 16'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        pulse_cnt += int'(abl_load);
        check_strobe("areq_idle", 1'b0, 16'h0202);
        check_eq("areq_pulses", 16'(pulse_cnt), 16'd3);
        check_eq("areq_pc", {pch_out, pcl_out}, 16'h0203);

        // Reset in the middle of VEC_HI, then replay with new vector data.
        vec_lo_v = 8'h78;
        vec_hi_v = 8'h56;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check_eq("mid_vechi_pcl", {8'h00, pcl_out}, 16'h0078);
        reset = 1'b1;
        #1;
        check_reset_state("rst_mid");
        step();
        reset = 1'b0;
        run_vector("replay", 16'h5678);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check_eq("replay_inc", {pch_out, pcl_out}, 16'h5679);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
